fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 110 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects for the decode and execute stages, plus load-use stall/bubble control.
// Latency: cmp_fw_o and stall_o are combinational; alu_fw_o follows decode by one cycle.
// Backpressure: stall_o holds PC and IF/ID for LOAD_STALL unpaused cycles; pause freezes all state.
module fwd_hazard_unit #(
    parameter int RN_W       = 5,
    parameter int NSRC       = 2,
    parameter int LOAD_STALL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pause,
    input  logic                 flush,
    input  logic [NSRC*RN_W-1:0] id_rn_i,
    input  logic [NSRC-1:0]      id_vld_i,
    input  logic                 ex_we_i,
    input  logic [RN_W-1:0]      ex_wr_rn_i,
    input  logic                 ex_is_load_i,
    input  logic                 mem_we_i,
    input  logic [RN_W-1:0]      mem_wr_rn_i,
    output logic [NSRC*3-1:0]    cmp_fw_o,
    output logic [NSRC*3-1:0]    alu_fw_o,
    output logic                 stall_o,
    output logic                 bubble_o
);

    localparam logic [2:0] FW_NOP   = 3'b000;
    localparam logic [2:0] FW_ALU   = 3'b001;
    localparam logic [2:0] FW_MEM   = 3'b010;
    localparam logic [2:0] REM_INIT = 3'(LOAD_STALL - 1);

    typedef enum logic {IDLE, STALL} state_t;

    state_t                 state;
    logic [2:0]             rem;
    logic [NSRC*RN_W-1:0]   rn_q;
    logic [NSRC-1:0]        vld_q;
    logic                   hazard;

    // EX is checked first so the youngest producer wins on a double match.
    function automatic logic [2:0] fw_sel(
        input logic [RN_W-1:0] rn,
        input logic            vld,
        input logic            ex_we,
        input logic [RN_W-1:0] ex_rn,
        input logic            mem_we,
        input logic [RN_W-1:0] mem_rn
    );
        logic [2:0] sel;
        sel = FW_NOP;
        if (vld && rn != '0) begin
            if (ex_we && ex_rn == rn)
                sel = FW_ALU;
            else if (mem_we && mem_rn == rn)
                sel = FW_MEM;
        end
        return sel;
    endfunction

    always_comb begin
        hazard   = 1'b0;
        cmp_fw_o = '0;
        alu_fw_o = '0;
        for (int k = 0; k < NSRC; k++) begin
            cmp_fw_o[k*3 +: 3] = fw_sel(id_rn_i[k*RN_W +: RN_W], id_vld_i[k],
                                        ex_we_i, ex_wr_rn_i, mem_we_i, mem_wr_rn_i);
            if (!rst)
                alu_fw_o[k*3 +: 3] = fw_sel(rn_q[k*RN_W +: RN_W], vld_q[k],
                                            ex_we_i, ex_wr_rn_i, mem_we_i, mem_wr_rn_i);
            if (id_vld_i[k] && id_rn_i[k*RN_W +: RN_W] == ex_wr_rn_i)
                hazard = 1'b1;
        end
        hazard = hazard & ex_we_i & ex_is_load_i & (ex_wr_rn_i != '0);
    end

    assign stall_o = !rst && !flush && (state == STALL || hazard);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            rn_q     <= '0;
            vld_q    <= '0;
            bubble_o <= 1'b0;
        end else if (!pause) begin
            bubble_o <= stall_o & ~flush;
            // A stalled or flushed decode slot becomes a bubble in ID/EX.
            if (flush || stall_o) begin
                rn_q  <= '0;
                vld_q <= '0;
            end else begin
                rn_q  <= id_rn_i;
                vld_q <= id_vld_i;
            end
            if (flush) begin
                state <= IDLE;
                rem   <= '0;
            end else if (state == IDLE) begin
                if (hazard && LOAD_STALL > 1) begin
                    state <= STALL;
                    rem   <= REM_INIT;
                end
            end else begin
                rem <= rem - 3'd1;
                if (rem == 3'd1)
                    state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: expected outputs queued at drive time, compared at negedge.
module tb_fwd_hazard_unit;

    localparam int RN_W = 5;
    localparam int NSRC = 2;
    localparam int LS   = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pause;
    logic                 flush;
    logic [NSRC*RN_W-1:0] id_rn_i;
    logic [NSRC-1:0]      id_vld_i;
    logic                 ex_we_i;
    logic [RN_W-1:0]      ex_wr_rn_i;
    logic                 ex_is_load_i;
    logic                 mem_we_i;
    logic [RN_W-1:0]      mem_wr_rn_i;
    logic [NSRC*3-1:0]    cmp_fw_o;
    logic [NSRC*3-1:0]    alu_fw_o;
    logic                 stall_o;
    logic                 bubble_o;

    fwd_hazard_unit #(.RN_W(RN_W), .NSRC(NSRC), .LOAD_STALL(LS)) dut (
        .clk(clk), .rst(rst), .pause(pause), .flush(flush),
        .id_rn_i(id_rn_i), .id_vld_i(id_vld_i),
        .ex_we_i(ex_we_i), .ex_wr_rn_i(ex_wr_rn_i), .ex_is_load_i(ex_is_load_i),
        .mem_we_i(mem_we_i), .mem_wr_rn_i(mem_wr_rn_i),
        .cmp_fw_o(cmp_fw_o), .alu_fw_o(alu_fw_o),
        .stall_o(stall_o), .bubble_o(bubble_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] cmp;
        logic [5:0] alu;
        logic       stall;
        logic       bubble;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   stall_cnt = 0;

    // Reference model state: stall cycles still owed after the current one.
    int          m_left = 0;
    logic [9:0]  m_rn_q = '0;
    logic [1:0]  m_vld_q = '0;
    logic        m_bubble = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_sel(input logic [4:0] rn, input logic v);
        if (!v || rn == 5'd0) return 3'b000;
        if (ex_we_i && ex_wr_rn_i == rn) return 3'b001;
        if (mem_we_i && mem_wr_rn_i == rn) return 3'b010;
        return 3'b000;
    endfunction

    function automatic logic m_hazard();
        logic h;
        h = 1'b0;
        for (int k = 0; k < NSRC; k++)
            if (id_vld_i[k] && id_rn_i[k*RN_W +: RN_W] == ex_wr_rn_i) h = 1'b1;
        return h && ex_we_i && ex_is_load_i && (ex_wr_rn_i != 5'd0);
    endfunction

    task automatic step(input int r, input int p, input int f, input int a1, input int a0,
                        input int v, input int xwe, input int xrn, input int xld,
                        input int mwe, input int mrn);
        exp_t e;
        logic hz;
        rst          = 1'(r);
        pause        = 1'(p);
        flush        = 1'(f);
        id_rn_i      = {5'(a1), 5'(a0)};
        id_vld_i     = 2'(v);
        ex_we_i      = 1'(xwe);
        ex_wr_rn_i   = 5'(xrn);
        ex_is_load_i = 1'(xld);
        mem_we_i     = 1'(mwe);
        mem_wr_rn_i  = 5'(mrn);
        if (rst) begin
            m_left = 0; m_rn_q = '0; m_vld_q = '0; m_bubble = 1'b0;
        end
        hz       = m_hazard();
        e.cmp    = {m_sel(id_rn_i[9:5], id_vld_i[1]), m_sel(id_rn_i[4:0], id_vld_i[0])};
        e.alu    = rst ? 6'd0 : {m_sel(m_rn_q[9:5], m_vld_q[1]), m_sel(m_rn_q[4:0], m_vld_q[0])};
        e.stall  = !rst && !flush && (m_left > 0 || hz);
        e.bubble = m_bubble;
        sb_q.push_back(e);
        @(posedge clk);
        if (!rst && !pause) begin
            m_bubble = e.stall;
            if (flush || e.stall) begin
                m_rn_q = '0; m_vld_q = '0;
            end else begin
                m_rn_q = id_rn_i; m_vld_q = id_vld_i;
            end
            if (flush)           m_left = 0;
            else if (m_left > 0) m_left = m_left - 1;
            else if (hz)         m_left = LS - 1;
        end
        #1;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            chk("cmp_fw", 32'(cmp_fw_o), 32'(sb_e.cmp));
            chk("alu_fw", 32'(alu_fw_o), 32'(sb_e.alu));
            chk("stall",  32'(stall_o),  32'(sb_e.stall));
            chk("bubble", 32'(bubble_o), 32'(sb_e.bubble));
            if (stall_o) stall_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time budget exceeded");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pause = 1'b0; flush = 1'b0;
        id_rn_i = '0; id_vld_i = '0;
        ex_we_i = 1'b0; ex_wr_rn_i = '0; ex_is_load_i = 1'b0;
        mem_we_i = 1'b0; mem_wr_rn_i = '0;
        @(posedge clk); #1;

        // Reset: cmp stays live, stall and alu forced quiet even with a load hazard present.
        step(1, 0, 0, 3, 3, 3, 1, 3, 1, 1, 3);
        step(1, 0, 0, 3, 3, 3, 1, 3, 1, 1, 3);

        // Double EX/MEM match picks ALU; next cycle the registered copy agrees.
        step(0, 0, 0, 3, 3, 3, 1, 3, 0, 1, 3);
        step(0, 0, 0, 3, 3, 3, 1, 3, 0, 1, 3);
        step(0, 0, 0, 9, 4, 3, 0, 4, 0, 1, 4);
        step(0, 0, 0, 4, 6, 3, 1, 6, 0, 1, 4);

        // Register zero and invalid operands never forward; load to r0 is no hazard.
        step(0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 0);
        step(0, 0, 0, 7, 7, 2, 1, 7, 0, 0, 0);
        step(0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0);
        idle_step();

        // Load-use stall of LS cycles.
        stall_cnt = 0;
        step(0, 0, 0, 1, 5, 3, 1, 5, 1, 0, 0);
        repeat (4) step(0, 0, 0, 1, 5, 3, 0, 0, 0, 1, 5);
        chk("stall_len", 32'(stall_cnt), 32'(LS));
        idle_step();

        // Two paused cycles inside the stall stretch it to LS+2.
        stall_cnt = 0;
        step(0, 0, 0, 1, 5, 3, 1, 5, 1, 0, 0);
        step(0, 0, 0, 1, 5, 3, 0, 0, 0, 1, 5);
        step(0, 1, 0, 1, 5, 3, 0, 0, 0, 1, 5);
        step(0, 1, 0, 1, 5, 3, 0, 0, 0, 1, 5);
        step(0, 0, 0, 1, 5, 3, 0, 0, 0, 1, 5);
        step(0, 0, 0, 1, 5, 3, 0, 0, 0, 1, 5);
        chk("stall_len_pause", 32'(stall_cnt), 32'(LS + 2));
        idle_step();

        // Flush during STALL returns to IDLE with cleared operands.
        step(0, 0, 0, 5, 5, 3, 1, 5, 1, 0, 0);
        step(0, 0, 1, 5, 5, 3, 0, 0, 0, 1, 5);
        step(0, 0, 0, 5, 5, 3, 0, 0, 0, 1, 5);
        idle_step();

        // Reset mid-stall aborts it at once; first edge afterwards behaves as IDLE.
        step(0, 0, 0, 2, 6, 3, 1, 6, 1, 0, 0);
        step(0, 0, 0, 2, 6, 3, 0, 0, 0, 1, 6);
        step(1, 0, 0, 2, 6, 3, 1, 6, 1, 0, 0);
        stall_cnt = 0;
        step(0, 0, 0, 2, 6, 3, 1, 6, 1, 0, 0);
        repeat (3) step(0, 0, 0, 2, 6, 3, 0, 0, 0, 1, 6);
        chk("stall_len_after_rst", 32'(stall_cnt), 32'(LS));

        // Random traffic over a small register range to force collisions.
        for (int i = 0; i < 80; i++)
            step(0, int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 9) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 3));
        idle_step();

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
